// File: rtl/spoofer_pkg.sv
// Shared types for the Avalon-ST spoofer stream generator.
package spoofer_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_CONST = 2'd1,
    MODE_STEP  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/spoofer_chan_counter.sv
// Per-channel wrapping counter; advances by inc when inc_en, wraps past MAX_NUM.
module spoofer_chan_counter #(
  parameter int              WIDTH   = 24,
  parameter longint unsigned MAX_NUM = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic [WIDTH-1:0] inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH:0] LIM = MAX_NUM[WIDTH:0];
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  // One extra bit so the overflow past MAX_NUM is visible before wrapping.
  logic [WIDTH:0] sum;
  assign sum = {1'b0, count} + {1'b0, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (inc_en) count <= (sum > LIM) ? WIDTH'(sum - LIM - ONE) : sum[WIDTH-1:0];
  end

endmodule

// File: rtl/spoofer_stream_gen.sv
// Multi-channel Avalon-ST packet generator: round-robin channels, per-channel
// counting data (COUNT/STEP) or a constant word (CONST), fixed-length packets.
module spoofer_stream_gen
  import spoofer_pkg::*;
#(
  parameter int              WIDTH   = 24,
  parameter int              DATA_W  = 32,
  parameter int              NUM_CH  = 4,
  parameter int              PKT_LEN = 16,
  parameter longint unsigned MAX_NUM = (64'd1 << WIDTH) - 64'd1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          en,
  input  logic [1:0]                                    mode,
  input  logic [WIDTH-1:0]                              step,
  input  logic [DATA_W-1:0]                             const_val,
  input  logic                                          src_ready,
  output logic                                          src_valid,
  output logic [DATA_W-1:0]                             src_data,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] src_channel,
  output logic                                          src_sop,
  output logic                                          src_eop,
  output logic                                          busy
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat;
  logic [CH_W-1:0]     ch;
  logic [1:0]          mode_q;
  logic [WIDTH-1:0]    step_q;
  logic [DATA_W-1:0]   const_q;

  logic [NUM_CH-1:0][WIDTH-1:0] counts;
  logic [NUM_CH-1:0]            inc_en;
  logic [WIDTH-1:0]             cur_count;

  logic              valid, accept, sop_b, eop_b;
  logic [1:0]        mode_eff;
  logic [WIDTH-1:0]  step_eff, inc;
  logic [DATA_W-1:0] const_eff;

  assign valid  = (state != ST_IDLE);
  assign accept = valid & src_ready;
  assign sop_b  = (beat == '0);
  assign eop_b  = (beat == LAST_BEAT);

  // Config is taken live on the sop beat and frozen for the rest of the packet.
  assign mode_eff  = sop_b ? mode      : mode_q;
  assign step_eff  = sop_b ? step      : step_q;
  assign const_eff = sop_b ? const_val : const_q;
  assign inc       = (mode_eff == MODE_STEP) ? step_eff : WIDTH'(1);

  always_comb begin
    cur_count = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch == CH_W'(i)) cur_count = counts[i];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign inc_en[i] = accept && (ch == CH_W'(i)) && (mode_eff != MODE_CONST);
    spoofer_chan_counter #(.WIDTH(WIDTH), .MAX_NUM(MAX_NUM)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_en(inc_en[i]),
      .inc   (inc),
      .count (counts[i])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_RUN;
      ST_RUN:
        if (!en) begin
          // An unaccepted sop beat is a clean boundary; anything else must finish.
          if (!accept && sop_b)      state_nxt = ST_IDLE;
          else if (accept && eop_b)  state_nxt = ST_IDLE;
          else                       state_nxt = ST_DRAIN;
        end
      ST_DRAIN: if (accept && eop_b) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      beat    <= '0;
      ch      <= '0;
      mode_q  <= '0;
      step_q  <= '0;
      const_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (sop_b) begin
          mode_q  <= mode;
          step_q  <= step;
          const_q <= const_val;
        end
        if (eop_b) begin
          beat <= '0;
          ch   <= (ch == LAST_CH) ? '0 : ch + 1'b1;
        end else begin
          beat <= beat + 1'b1;
        end
      end
    end
  end

  assign src_valid   = valid;
  assign src_data    = !valid ? '0 :
                       (mode_eff == MODE_CONST) ? const_eff : DATA_W'(cur_count);
  assign src_channel = ch;
  assign src_sop     = valid & sop_b;
  assign src_eop     = valid & eop_b;
  assign busy        = valid;

endmodule
